// File: rtl/multiplier_pkg.sv
// Shared types and constants for the shift-and-add sequential multiplier.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_N = 8;

endpackage

// File: rtl/sequential_multiplier_if.sv
// Host-side handshake and operand/result bundle of the sequential multiplier.
interface sequential_multiplier_if #(
  parameter int N = multiplier_pkg::MULT_N
);

  logic             start;
  logic [N-1:0]     Min;
  logic [N-1:0]     Qin;
  logic             ready;
  logic [2*N-1:0]   AQ;

  modport master (
    output start,
    output Min,
    output Qin,
    input  ready,
    input  AQ
  );

  modport slave (
    input  start,
    input  Min,
    input  Qin,
    output ready,
    output AQ
  );

endinterface

// File: rtl/multiplier_datapath.sv
// M/A/C/Q register file with the conditional add and the combined right shift.
module multiplier_datapath
  import multiplier_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic             clock,
  input  logic             n_rst,
  input  logic             load,
  input  logic             step,
  input  logic [N-1:0]     min,
  input  logic [N-1:0]     qin,
  output logic [2*N-1:0]   aq
);

  logic [N-1:0] m_r;
  logic [N-1:0] a_r;
  logic [N-1:0] q_r;
  logic         c_r;
  logic [N:0]   sum_s;

  // Partial-product add at N+1 bits; C is always clear here, so the sum never overflows.
  always_comb begin
    sum_s = {c_r, a_r};
    if (q_r[0]) begin
      sum_s = {c_r, a_r} + {1'b0, m_r};
    end else begin
      sum_s = {c_r, a_r};
    end
  end

  // Operand load and one shift-and-add step per cycle.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      m_r <= {N{1'b0}};
      a_r <= {N{1'b0}};
      q_r <= {N{1'b0}};
      c_r <= 1'b0;
    end else if (load) begin
      m_r <= min;
      a_r <= {N{1'b0}};
      q_r <= qin;
      c_r <= 1'b0;
    end else if (step) begin
      {c_r, a_r, q_r} <= {1'b0, sum_s, q_r[N-1:1]};
    end
  end

  assign aq = {a_r, q_r};

endmodule

// File: rtl/sequential_multiplier.sv
// Top level: handshake FSM and step counter around the multiplier datapath.
module sequential_multiplier
  import multiplier_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic                    clock,
  input  logic                    n_rst,
  sequential_multiplier_if.slave  bus
);

  localparam int             CW         = $clog2(N + 1);
  localparam logic [CW-1:0]  LAST_COUNT = CW'(N - 1);

  mult_state_t     state_r;
  mult_state_t     state_next_s;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_next_s;
  logic            ready_r;
  logic            load_s;
  logic            step_s;
  logic [2*N-1:0]  aq_s;

  // Next-state, counter and datapath control decode.
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          load_s       = 1'b1;
          count_next_s = {CW{1'b0}};
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        step_s       = 1'b1;
        count_next_s = count_r + CW'(1);
        // The step that takes the counter to N is the last one.
        if (count_r == LAST_COUNT) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_next_s = DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, counter and registered ready flag.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
      count_r <= {CW{1'b0}};
      ready_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      ready_r <= (state_next_s == DONE);
    end
  end

  multiplier_datapath #(
    .N (N)
  ) u_datapath (
    .clock (clock),
    .n_rst (n_rst),
    .load  (load_s),
    .step  (step_s),
    .min   (bus.Min),
    .qin   (bus.Qin),
    .aq    (aq_s)
  );

  assign bus.ready = ready_r;
  assign bus.AQ    = aq_s;

endmodule

// File: tb/tb_sequential_multiplier.sv
// Self-checking bench: directed vector table, reset and operand-change corners,
// random N=8 sweep and exhaustive N=4 sweep, with a product scoreboard.
module tb_sequential_multiplier;

  logic clock = 1'b0;
  logic n_rst = 1'b1;

  sequential_multiplier_if #(.N(8)) bus8 ();
  sequential_multiplier_if #(.N(4)) bus4 ();

  sequential_multiplier #(.N(8)) dut8 (.clock(clock), .n_rst(n_rst), .bus(bus8));
  sequential_multiplier #(.N(4)) dut4 (.clock(clock), .n_rst(n_rst), .bus(bus4));

  always #10 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    bit          scramble;
    int          hold;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit use4, input logic s, input logic [7:0] a, input logic [7:0] b);
    if (use4) begin
      bus4.start = s;
      bus4.Min   = a[3:0];
      bus4.Qin   = b[3:0];
    end else begin
      bus8.start = s;
      bus8.Min   = a;
      bus8.Qin   = b;
    end
  endtask

  function automatic logic get_ready(input bit use4);
    return use4 ? bus4.ready : bus8.ready;
  endfunction

  function automatic logic [15:0] get_aq(input bit use4);
    return use4 ? {8'd0, bus4.AQ} : bus8.AQ;
  endfunction

  // One full handshake: load, wait for ready, check, hold, release.
  task automatic run_op(input bit use4, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input bit scramble, input int hold);
    int lat;
    int n;
    logic [15:0] want;
    logic [15:0] qload;
    n = use4 ? 4 : 8;
    qload = use4 ? {12'd0, b[3:0]} : {8'd0, b};
    @(negedge clock);
    drive(use4, 1'b1, a, b);
    sb_q.push_back(exp);
    @(posedge clock);
    #1;
    check("aq_load", get_aq(use4), qload);
    if (scramble) begin
      drive(use4, 1'b1, ~a, b ^ 8'h5a);
    end
    lat = 0;
    while (lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
      if (get_ready(use4)) break;
    end
    check("latency", lat, n);
    want = sb_q.pop_front();
    check("product", get_aq(use4), want);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check("ready_hold", get_ready(use4), 1'b1);
      check("aq_hold", get_aq(use4), want);
    end
    @(negedge clock);
    drive(use4, 1'b0, a, b);
    @(posedge clock);
    #1;
    check("ready_fall", get_ready(use4), 1'b0);
    check("aq_keep", get_aq(use4), want);
  endtask

  initial begin
    vec_t vecs[5];
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] ia;
    logic [7:0] ib;

    vecs[0] = '{a: 8'd3,   b: 8'd5,   exp: 16'd15,    scramble: 1'b0, hold: 3};
    vecs[1] = '{a: 8'd255, b: 8'd255, exp: 16'd65025, scramble: 1'b0, hold: 1};
    vecs[2] = '{a: 8'd0,   b: 8'd200, exp: 16'd0,     scramble: 1'b0, hold: 0};
    vecs[3] = '{a: 8'd200, b: 8'd0,   exp: 16'd0,     scramble: 1'b0, hold: 0};
    vecs[4] = '{a: 8'd12,  b: 8'd13,  exp: 16'd156,   scramble: 1'b1, hold: 0};

    drive(1'b0, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 8'd0, 8'd0);
    #2;
    n_rst = 1'b0;
    #1;
    check("rst_ready", bus8.ready, 1'b0);
    check("rst_aq", bus8.AQ, 16'd0);
    check("rst_ready4", bus4.ready, 1'b0);
    check("rst_aq4", bus4.AQ, 8'd0);
    repeat (2) @(negedge clock);
    n_rst = 1'b1;

    foreach (vecs[i]) begin
      run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].scramble, vecs[i].hold);
    end

    // Asynchronous reset in the middle of a calculation.
    @(negedge clock);
    drive(1'b0, 1'b1, 8'd100, 8'd100);
    repeat (4) @(posedge clock);
    #5;
    n_rst = 1'b0;
    #1;
    check("midrst_ready", bus8.ready, 1'b0);
    check("midrst_aq", bus8.AQ, 16'd0);
    @(negedge clock);
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    @(negedge clock);
    n_rst = 1'b1;
    run_op(1'b0, 8'd7, 8'd9, 16'd63, 1'b0, 0);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(1'b0, ra, rb, {8'd0, ra} * {8'd0, rb}, 1'b0, 0);
    end

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        ia = 8'(x);
        ib = 8'(y);
        run_op(1'b1, ia, ib, {12'd0, ia[3:0]} * {12'd0, ib[3:0]}, 1'b0, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
